irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 107 ++++++++++
 tb/tb_irq_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - four-line prioritised interrupt controller on the cpu user bus
module irq_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq_req,
    input  logic [7:0] usermem_address,
    inout  wire  [7:0] usermem_data,
    input  logic       rw,
    output logic       interrupt
);

    logic [3:0] sync1, s, s_prev;
    logic [3:0] pend, mask, mode, insvc;
    logic       vec_rd_prev;

    logic       hit, rd_hit, wr_hit, vec_rd, ack, eoi, act;
    logic [1:0] offset, id;
    logic [3:0] elig, cand, w1c, ack_clr, pend_next;
    logic [7:0] rdata;

    assign hit    = (usermem_address >= BASE_ADDR) &&
                    ({1'b0, usermem_address} <= ({1'b0, BASE_ADDR} + 9'd3));
    assign offset = usermem_address[1:0] - BASE_ADDR[1:0];
    assign rd_hit = hit && !rw;
    assign wr_hit = hit && rw;
    assign vec_rd = rd_hit && (offset == 2'd3);
    assign eoi    = wr_hit && (offset == 2'd3);

    // Only lines strictly below the highest-priority in-service line may interrupt.
    always_comb begin
        casez (insvc)
            4'b???1: elig = 4'b0000;
            4'b??10: elig = 4'b0001;
            4'b?100: elig = 4'b0011;
            4'b1000: elig = 4'b0111;
            default: elig = 4'b1111;
        endcase
    end

    assign cand = pend & mask & elig;

    always_comb begin
        act = 1'b1;
        id  = 2'd0;
        casez (cand)
            4'b???1: id = 2'd0;
            4'b??10: id = 2'd1;
            4'b?100: id = 2'd2;
            4'b1000: id = 2'd3;
            default: act = 1'b0;
        endcase
    end

    always_comb begin
        rdata = 8'h00;
        case (offset)
            2'd0: rdata = {4'b0000, pend};
            2'd1: rdata = {4'b0000, mask};
            2'd2: rdata = {4'b0000, mode};
            2'd3: rdata = {act, 5'b00000, id};
            default: rdata = 8'h00;
        endcase
    end

    assign usermem_data = rd_hit ? rdata : 8'hzz;

    // A held VEC read acknowledges only on its first cycle.
    assign ack     = vec_rd && !vec_rd_prev && act;
    assign w1c     = (wr_hit && (offset == 2'd0)) ? usermem_data[3:0] : 4'b0000;
    assign ack_clr = ack ? (4'b0001 << id) : 4'b0000;

    // Edge lines: a new edge beats any clear. Level lines simply follow s.
    assign pend_next = (mode & ((s & ~s_prev) | (pend & ~(w1c | ack_clr)))) |
                       (~mode & s);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= 4'h0;
            s           <= 4'h0;
            s_prev      <= 4'h0;
            pend        <= 4'h0;
            mask        <= 4'h0;
            mode        <= 4'hF;
            insvc       <= 4'h0;
            vec_rd_prev <= 1'b0;
            interrupt   <= 1'b0;
        end else begin
            sync1       <= irq_req;
            s           <= sync1;
            s_prev      <= s;
            pend        <= pend_next;
            vec_rd_prev <= vec_rd;
            interrupt   <= act;
            if (wr_hit && (offset == 2'd1))
                mask <= usermem_data[3:0];
            if (wr_hit && (offset == 2'd2))
                mode <= usermem_data[3:0];
            if (ack)
                insvc <= insvc | ack_clr;
            else if (eoi)
                insvc <= insvc & (insvc - 4'd1);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl with a rule-level reference model
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq = 4'h0;
    logic [7:0] addr = 8'h00;
    logic       rw = 1'b0;
    logic       drv = 1'b0;
    logic [7:0] wdata = 8'h00;
    tri1  [7:0] bus;
    wire        interrupt;

    assign bus = drv ? wdata : 8'hzz;

    irq_ctrl #(.BASE_ADDR(8'hF0)) dut (
        .clk             (clk),
        .reset           (reset),
        .irq_req         (irq),
        .usermem_address (addr),
        .usermem_data    (bus),
        .rw              (rw),
        .interrupt       (interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         is_bus;
        logic [7:0] exp;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        chk_t       c;
        logic [7:0] got;
        while (q.size() > 0) begin
            c   = q.pop_front();
            got = c.is_bus ? bus : {7'b0, interrupt};
            checks++;
            if (got !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", c.name, got, c.exp, $time);
            end
        end
    end

    logic [3:0] m_pend, m_mask, m_mode, m_insvc;
    logic [3:0] h1, h2, h3;
    bit         m_int, m_prev_vec, en_model = 0;

    function automatic int lowest(logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return 4;
    endfunction

    function automatic logic [7:0] m_vec();
        for (int i = 0; i < 4; i++)
            if (m_pend[i] && m_mask[i] && (i < lowest(m_insvc)))
                return {1'b1, 5'b0, 2'(i)};
        return 8'h00;
    endfunction

    function automatic logic [7:0] m_read(int off);
        case (off)
            0: return {4'b0, m_pend};
            1: return {4'b0, m_mask};
            2: return {4'b0, m_mode};
            default: return m_vec();
        endcase
    endfunction

    always @(posedge clk) begin
        bit         hit, ack;
        int         off, lo;
        logic [7:0] v;
        logic [3:0] np;
        hit = (addr >= 8'hF0) && (addr <= 8'hF3);
        off = int'(addr) - 32'hF0;
        if (reset) begin
            m_pend = 0; m_mask = 0; m_mode = 4'hF; m_insvc = 0;
            h1 = 0; h2 = 0; h3 = 0; m_int = 0; m_prev_vec = 0;
        end else begin
            v   = m_vec();
            ack = hit && off == 3 && !rw && !m_prev_vec && v[7];
            np  = m_pend;
            for (int i = 0; i < 4; i++) begin
                if (!m_mode[i])
                    np[i] = h2[i];
                else if (h2[i] && !h3[i])
                    np[i] = 1'b1;
                else if ((hit && off == 0 && rw && bus[i]) || (ack && int'(v[1:0]) == i))
                    np[i] = 1'b0;
            end
            lo = lowest(m_insvc);
            if (ack)
                m_insvc[v[1:0]] = 1'b1;
            else if (hit && off == 3 && rw && lo < 4)
                m_insvc[lo] = 1'b0;
            if (hit && rw && off == 1) m_mask = bus[3:0];
            if (hit && rw && off == 2) m_mode = bus[3:0];
            m_prev_vec = hit && off == 3 && !rw;
            m_int      = v[7];
            m_pend     = np;
            h3 = h2; h2 = h1; h1 = irq;
        end
        #2;
        if (en_model) begin
            q.push_back('{"model_int", 1'b0, {7'b0, m_int}});
            if (!drv) begin
                hit = (addr >= 8'hF0) && (addr <= 8'hF3);
                off = int'(addr) - 32'hF0;
                q.push_back('{"model_bus", 1'b1, (hit && !rw) ? m_read(off) : 8'hFF});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        addr = 8'h00; rw = 0; drv = 0;
        repeat (n) step();
    endtask

    task automatic rd(logic [7:0] a, logic [7:0] e, string name);
        addr = a; rw = 0; drv = 0;
        q.push_back('{name, 1'b1, e});
        step();
    endtask

    task automatic wr(logic [7:0] a, logic [7:0] d);
        addr = a; rw = 1; drv = 1; wdata = d;
        step();
    endtask

    task automatic exp_int(string name, bit e);
        q.push_back('{name, 1'b0, {7'b0, e}});
    endtask

    task automatic check_eq(string name, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_int(int n, string name);
        int k;
        k = 0;
        addr = 8'h00; rw = 0; drv = 0;
        while ((interrupt !== 1'b1) && (k < n)) begin
            step();
            k++;
        end
        checks++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("FAIL %s: wait expired after %0d clks at %0t", name, n, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1; irq = 0;
        idle(2);
        reset = 0;
    endtask

    initial begin
        #1;
        do_reset();
        check_eq("reset_state_int", {7'b0, interrupt}, 8'h00);
        check_eq("reset_state_bus", bus, 8'hFF);
        en_model = 1;
        exp_int("reset_int", 0);
        rd(8'hF2, 8'h0F, "reset_mode");
        rd(8'hF1, 8'h00, "reset_mask");

        wr(8'hF1, 8'h04);
        irq = 4'h4; idle(1); irq = 4'h0; idle(2);
        exp_int("lat_3rd_edge", 0);
        idle(1);
        exp_int("lat_4th_edge", 1);
        rd(8'hF3, 8'h82, "vec_line2");
        idle(1);
        exp_int("after_ack_int", 0);
        rd(8'hF0, 8'h00, "after_ack_pend");
        irq = 4'h4; idle(1); irq = 4'h0; idle(5);
        exp_int("in_service_blocks", 0);
        wr(8'hF3, 8'h00);
        exp_int("eoi_1clk", 0);
        idle(1);
        exp_int("eoi_2clk", 1);

        do_reset();
        wr(8'hF1, 8'h0F);
        irq = 4'h8; idle(5);
        exp_int("line3_int", 1);
        rd(8'hF3, 8'h83, "vec_line3");
        idle(1); irq = 4'h0; idle(3); irq = 4'h8; idle(5);
        exp_int("line3_blocked_int", 0);
        rd(8'hF3, 8'h00, "vec_line3_blocked");
        idle(1); irq = 4'hA; idle(5);
        exp_int("line1_over_3_int", 1);
        rd(8'hF3, 8'h81, "vec_line1");

        do_reset();
        wr(8'hF2, 8'h00);
        irq = 4'h1; idle(4);
        rd(8'hF0, 8'h01, "level_pend");
        wr(8'hF0, 8'h01);
        rd(8'hF0, 8'h01, "level_w1c_ignored");
        irq = 4'h0; idle(2);
        rd(8'hF0, 8'h01, "level_drop_2clk");
        rd(8'hF0, 8'h00, "level_drop_3clk");

        do_reset();
        wr(8'hF1, 8'h0F);
        irq = 4'h4; idle(1);
        irq = 4'h0; idle(1);
        irq = 4'h1; idle(2);
        rd(8'hF3, 8'h82, "held_vec_1");
        rd(8'hF3, 8'h80, "held_vec_2");
        rd(8'hF3, 8'h80, "held_vec_3");
        rd(8'hF0, 8'h01, "held_single_ack");
        rd(8'hEF, 8'hFF, "hiz_below");
        rd(8'hF4, 8'hFF, "hiz_above");
        addr = 8'hF3; rw = 1; drv = 0;
        q.push_back('{"hiz_write", 1'b1, 8'hFF});
        step();

        do_reset();
        wr(8'hF1, 8'h0F);
        irq = 4'h2;
        wait_int(8, "pre_reset_wait");
        exp_int("pre_reset_int", 1);
        reset = 1;
        wr(8'hF1, 8'h0F);
        reset = 0; irq = 4'h0;
        exp_int("reset_write_int", 0);
        rd(8'hF1, 8'h00, "reset_write_mask");
        rd(8'hF2, 8'h0F, "reset_write_mode");

        do_reset();
        repeat (400) begin
            int op;
            if ($urandom_range(0, 2) == 0) irq = 4'($urandom);
            op = $urandom_range(0, 6);
            case (op)
                0, 1: begin addr = 8'h00; rw = 0; drv = 0; end
                2: begin addr = 8'hF0 + 8'($urandom_range(0, 3)); rw = 0; drv = 0; end
                3: begin addr = 8'hF0 + 8'($urandom_range(0, 3)); rw = 1; drv = 1; wdata = 8'($urandom); end
                4: begin addr = ($urandom_range(0, 1) == 0) ? 8'hEF : 8'hF4; rw = 0; drv = 0; end
                5: begin addr = 8'hF1; rw = 1; drv = 1; wdata = 8'($urandom_range(8, 15)); end
                default: begin addr = 8'hF3; rw = 0; drv = 0; end
            endcase
            step();
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
